// File: rtl/dense_loop_addr_gen_if.sv
// ---------------------------------------------------------------------------
// dense_loop_addr_gen_if
// Handshake and address bus between the dense-layer sequencer (master) and
// the dense loop address generator (slave).
//
// Signals:
//   start_ready_in        sequencer -> generator  latch config, restart loop
//   next_ready_in         sequencer -> generator  request first/next tuple
//   input_base_addr_in    sequencer -> generator  input activation base
//   weight_base_addr_in   sequencer -> generator  weight matrix base [m][k]
//   output_base_addr_in   sequencer -> generator  output/bias base
//   m_size_in             sequencer -> generator  number of outputs
//   chw_size_in           sequencer -> generator  reduction length
//   n_size_in             sequencer -> generator  batch size
//   input_addr_out        generator -> sequencer  current input address
//   weight_addr_out       generator -> sequencer  current weight address
//   output_addr_out       generator -> sequencer  current output address
//   k_last_out            generator -> sequencer  tuple is last of its row
//   ready_out             generator -> sequencer  tuple valid, not consumed
//   done_out              generator -> sequencer  whole loop consumed
// ---------------------------------------------------------------------------
interface dense_loop_addr_gen_if #(
   parameter int ADDR_BITS = 32,
   parameter int SIZE_BITS = 10
);
   logic                 start_ready_in;
   logic                 next_ready_in;
   logic [ADDR_BITS-1:0] input_base_addr_in;
   logic [ADDR_BITS-1:0] weight_base_addr_in;
   logic [ADDR_BITS-1:0] output_base_addr_in;
   logic [SIZE_BITS-1:0] m_size_in;
   logic [SIZE_BITS-1:0] chw_size_in;
   logic [SIZE_BITS-1:0] n_size_in;
   logic [ADDR_BITS-1:0] input_addr_out;
   logic [ADDR_BITS-1:0] weight_addr_out;
   logic [ADDR_BITS-1:0] output_addr_out;
   logic                 k_last_out;
   logic                 ready_out;
   logic                 done_out;

   // The sequencer drives requests and configuration, observes the tuple
   modport master (
      output start_ready_in, next_ready_in,
      output input_base_addr_in, weight_base_addr_in, output_base_addr_in,
      output m_size_in, chw_size_in, n_size_in,
      input  input_addr_out, weight_addr_out, output_addr_out,
      input  k_last_out, ready_out, done_out
   );

   // The address generator consumes requests and configuration, drives the tuple
   modport slave (
      input  start_ready_in, next_ready_in,
      input  input_base_addr_in, weight_base_addr_in, output_base_addr_in,
      input  m_size_in, chw_size_in, n_size_in,
      output input_addr_out, weight_addr_out, output_addr_out,
      output k_last_out, ready_out, done_out
   );
endinterface

// File: rtl/dense_loop_addr_gen.sv
// ---------------------------------------------------------------------------
// dense_loop_addr_gen
// Walks the dense-layer iteration space (batch n, then output m, then
// reduction k) and presents one (input, weight, output) BRAM address tuple
// per request. Addresses are built from running offsets, so no multiplier
// is needed.
//
// Ports:
//   clk_in   single clock
//   rst_in   asynchronous, active-low reset
//   bus      dense_loop_addr_gen_if.slave (handshake, config, tuple outputs)
// ---------------------------------------------------------------------------
module dense_loop_addr_gen #(
   parameter int ADDR_BITS = 32,
   parameter int SIZE_BITS = 10
) (
   input logic                  clk_in,
   input logic                  rst_in,
   dense_loop_addr_gen_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ARMED, FETCH, PRESENT, DONE} state_t;

   state_t state;
   state_t state_next;

   logic [ADDR_BITS-1:0] input_base;
   logic [ADDR_BITS-1:0] weight_base;
   logic [ADDR_BITS-1:0] output_base;
   logic [SIZE_BITS-1:0] m_size;
   logic [SIZE_BITS-1:0] chw_size;
   logic [SIZE_BITS-1:0] n_size;

   logic [SIZE_BITS-1:0] k_cnt;
   logic [SIZE_BITS-1:0] m_cnt;
   logic [SIZE_BITS-1:0] n_cnt;
   logic [ADDR_BITS-1:0] in_off;
   logic [ADDR_BITS-1:0] row_base;
   logic [ADDR_BITS-1:0] w_off;
   logic [ADDR_BITS-1:0] out_off;
   logic                 exhausted;

   logic [ADDR_BITS-1:0] input_addr;
   logic [ADDR_BITS-1:0] weight_addr;
   logic [ADDR_BITS-1:0] output_addr;
   logic                 k_last;
   logic                 ready;
   logic                 done;

   logic                 latch_cfg;
   logic                 load_tuple;
   logic                 finish;
   logic                 advance;

   logic                 zero_cfg;
   logic [ADDR_BITS-1:0] chw_ext;
   logic                 m_last;
   logic                 n_last;

   assign zero_cfg = (m_size == '0) || (chw_size == '0) || (n_size == '0);
   assign chw_ext  = {{(ADDR_BITS-SIZE_BITS){1'b0}}, chw_size};
   assign m_last   = (m_cnt == m_size - SIZE_BITS'(1));
   assign n_last   = (n_cnt == n_size - SIZE_BITS'(1));

   // State register; reset drops straight back to IDLE
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath strobes. A start request overrides everything,
   // including a pending next, so a running loop can always be aborted.
   always_comb begin
      state_next = state;
      latch_cfg  = 1'b0;
      load_tuple = 1'b0;
      finish     = 1'b0;
      advance    = 1'b0;
      if (bus.start_ready_in) begin
         latch_cfg  = 1'b1;
         state_next = bus.next_ready_in ? FETCH : ARMED;
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            ARMED: begin
               if (bus.next_ready_in) begin
                  state_next = FETCH;
               end
            end
            FETCH: begin
               if (zero_cfg || exhausted) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end else begin
                  load_tuple = 1'b1;
                  state_next = PRESENT;
               end
            end
            PRESENT: begin
               if (bus.next_ready_in) begin
                  advance    = 1'b1;
                  state_next = FETCH;
               end
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Config, loop counters, running offsets and the registered tuple.
   // The input offset rewinds to row_base at the end of each m row and
   // jumps a full row at the end of a batch; the weight offset only rewinds
   // at a batch boundary; the output offset never rewinds. The exhausted
   // flag is set when n wraps so FETCH only tests a single register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         input_base  <= '0;
         weight_base <= '0;
         output_base <= '0;
         m_size      <= '0;
         chw_size    <= '0;
         n_size      <= '0;
         k_cnt       <= '0;
         m_cnt       <= '0;
         n_cnt       <= '0;
         in_off      <= '0;
         row_base    <= '0;
         w_off       <= '0;
         out_off     <= '0;
         exhausted   <= 1'b0;
         input_addr  <= '0;
         weight_addr <= '0;
         output_addr <= '0;
         k_last      <= 1'b0;
         ready       <= 1'b0;
         done        <= 1'b0;
      end else if (latch_cfg) begin
         input_base  <= bus.input_base_addr_in;
         weight_base <= bus.weight_base_addr_in;
         output_base <= bus.output_base_addr_in;
         m_size      <= bus.m_size_in;
         chw_size    <= bus.chw_size_in;
         n_size      <= bus.n_size_in;
         k_cnt       <= '0;
         m_cnt       <= '0;
         n_cnt       <= '0;
         in_off      <= '0;
         row_base    <= '0;
         w_off       <= '0;
         out_off     <= '0;
         exhausted   <= 1'b0;
         ready       <= 1'b0;
         done        <= 1'b0;
      end else begin
         if (load_tuple) begin
            input_addr  <= input_base + in_off;
            weight_addr <= weight_base + w_off;
            output_addr <= output_base + out_off;
            k_last      <= (k_cnt == chw_size - SIZE_BITS'(1));
            ready       <= 1'b1;
         end
         if (finish) begin
            done  <= 1'b1;
            ready <= 1'b0;
         end
         if (advance) begin
            ready <= 1'b0;
            if (!k_last) begin
               k_cnt  <= k_cnt + SIZE_BITS'(1);
               in_off <= in_off + ADDR_BITS'(1);
               w_off  <= w_off + ADDR_BITS'(1);
            end else begin
               k_cnt   <= '0;
               out_off <= out_off + ADDR_BITS'(1);
               if (!m_last) begin
                  m_cnt  <= m_cnt + SIZE_BITS'(1);
                  in_off <= row_base;
                  w_off  <= w_off + ADDR_BITS'(1);
               end else begin
                  m_cnt <= '0;
                  w_off <= '0;
                  if (!n_last) begin
                     n_cnt    <= n_cnt + SIZE_BITS'(1);
                     row_base <= row_base + chw_ext;
                     in_off   <= row_base + chw_ext;
                  end else begin
                     n_cnt     <= '0;
                     exhausted <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.input_addr_out  = input_addr;
   assign bus.weight_addr_out = weight_addr;
   assign bus.output_addr_out = output_addr;
   assign bus.k_last_out      = k_last;
   assign bus.ready_out       = ready;
   assign bus.done_out        = done;

endmodule
